// File: rtl/turnstile_ctrl_p.sv
// Parametrised coin-operated turnstile: fare accumulation with saturating credit,
// unlock timeout, optional forced-push alarm and wrap-around pass/coin counters.
module turnstile_ctrl_p #(
    parameter int PRICE      = 2,
    parameter int CREDIT_MAX = 7,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 100,
    parameter int ALARM_EN   = 1,
    localparam int CW        = $clog2(CREDIT_MAX + 1),
    localparam int TW        = $clog2(TIMEOUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             coin_i,
    input  logic             push_i,
    input  logic             clr_alarm_i,
    output logic             locked_o,
    output logic             unlocked_o,
    output logic             alarm_o,
    output logic             timeout_o,
    output logic [CW-1:0]    credit_o,
    output logic [CNT_W-1:0] pass_count_o,
    output logic [CNT_W-1:0] coin_count_o
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        ALARM    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          coin_q;
    logic          push_q;
    logic          coin_ev;
    logic          push_ev;
    logic [CW-1:0] nc;
    logic [CW-1:0] credit_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic          pass_inc;
    logic          timeout_n;

    assign coin_ev = coin_i & ~coin_q;
    assign push_ev = push_i & ~push_q;

    // Credit after this cycle's coin; a coin beyond the limit is counted but not credited.
    always_comb begin
        nc = credit_o;
        if (coin_ev && (credit_o != CW'(CREDIT_MAX)))
            nc = credit_o + 1'b1;
    end

    always_comb begin
        state_n   = state;
        credit_n  = nc;
        timer_n   = timer;
        pass_inc  = 1'b0;
        timeout_n = 1'b0;
        case (state)
            LOCKED: begin
                if (nc >= CW'(PRICE)) begin
                    state_n  = UNLOCKED;
                    credit_n = nc - CW'(PRICE);
                    timer_n  = '0;
                end else if (push_ev && (ALARM_EN != 0)) begin
                    state_n = ALARM;
                end
            end
            UNLOCKED: begin
                if (push_ev) begin
                    pass_inc = 1'b1;
                    if (nc >= CW'(PRICE)) begin
                        credit_n = nc - CW'(PRICE);
                        timer_n  = '0;
                    end else begin
                        state_n = LOCKED;
                    end
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n   = LOCKED;
                    timeout_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ALARM: begin
                if (clr_alarm_i)
                    state_n = LOCKED;
            end
            default: state_n = LOCKED;
        endcase
    end

    // Edge registers reset high so an input held through reset produces no event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= LOCKED;
            coin_q       <= 1'b1;
            push_q       <= 1'b1;
            timer        <= '0;
            locked_o     <= 1'b1;
            unlocked_o   <= 1'b0;
            alarm_o      <= 1'b0;
            timeout_o    <= 1'b0;
            credit_o     <= '0;
            pass_count_o <= '0;
            coin_count_o <= '0;
        end else begin
            state      <= state_n;
            coin_q     <= coin_i;
            push_q     <= push_i;
            timer      <= timer_n;
            locked_o   <= (state_n != UNLOCKED);
            unlocked_o <= (state_n == UNLOCKED);
            alarm_o    <= (state_n == ALARM);
            timeout_o  <= timeout_n;
            credit_o   <= credit_n;
            if (pass_inc)
                pass_count_o <= pass_count_o + CNT_W'(1);
            if (coin_ev)
                coin_count_o <= coin_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_turnstile_ctrl_p.sv
// Bench for turnstile_ctrl_p: two configurations driven by shared stimulus, each
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_turnstile_ctrl_p;

    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coin = 1'b0;
    logic push = 1'b0;
    logic clr = 1'b0;

    // Instance a: the default test configuration.
    logic          a_locked, a_unlocked, a_alarm, a_to;
    logic [CW-1:0] a_credit;
    logic [7:0]    a_pass, a_coin;
    // Instance b: narrow counters, no alarm.
    logic          b_locked, b_unlocked, b_alarm, b_to;
    logic [CW-1:0] b_credit;
    logic [1:0]    b_pass, b_coin;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    turnstile_ctrl_p #(.PRICE(2), .CREDIT_MAX(7), .CNT_W(8), .TIMEOUT(10), .ALARM_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .coin_i(coin), .push_i(push), .clr_alarm_i(clr),
        .locked_o(a_locked), .unlocked_o(a_unlocked), .alarm_o(a_alarm), .timeout_o(a_to),
        .credit_o(a_credit), .pass_count_o(a_pass), .coin_count_o(a_coin)
    );

    turnstile_ctrl_p #(.PRICE(2), .CREDIT_MAX(7), .CNT_W(2), .TIMEOUT(10), .ALARM_EN(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .coin_i(coin), .push_i(push), .clr_alarm_i(clr),
        .locked_o(b_locked), .unlocked_o(b_unlocked), .alarm_o(b_alarm), .timeout_o(b_to),
        .credit_o(b_credit), .pass_count_o(b_pass), .coin_count_o(b_coin)
    );

    // Behavioural model, one slot per instance.
    int p_price[2]   = '{2, 2};
    int p_cmax[2]    = '{7, 7};
    int p_mod[2]     = '{256, 4};
    int p_timeout[2] = '{10, 10};
    bit p_alarm[2]   = '{1'b1, 1'b0};

    bit m_open[2];
    bit m_alarm[2];
    bit m_to[2];
    int m_credit[2];
    int m_idle[2];
    int m_pass[2];
    int m_coins[2];
    bit m_pc[2];
    bit m_pp[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input int i, input bit c, input bit p, input bit cl, input bit r);
        bit ce, pe;
        if (r) begin
            m_open[i] = 0; m_alarm[i] = 0; m_to[i] = 0;
            m_credit[i] = 0; m_idle[i] = 0; m_pass[i] = 0; m_coins[i] = 0;
            m_pc[i] = 1; m_pp[i] = 1;
            return;
        end
        ce = c && !m_pc[i];
        pe = p && !m_pp[i];
        m_pc[i] = c;
        m_pp[i] = p;
        m_to[i] = 0;
        if (ce) begin
            m_coins[i] = (m_coins[i] + 1) % p_mod[i];
            if (m_credit[i] < p_cmax[i]) m_credit[i]++;
        end
        if (m_alarm[i]) begin
            if (cl) m_alarm[i] = 0;
        end else if (!m_open[i]) begin
            if (m_credit[i] >= p_price[i]) begin
                m_credit[i] -= p_price[i];
                m_open[i] = 1;
                m_idle[i] = 0;
            end else if (pe && p_alarm[i]) begin
                m_alarm[i] = 1;
            end
        end else if (pe) begin
            m_pass[i] = (m_pass[i] + 1) % p_mod[i];
            if (m_credit[i] >= p_price[i]) begin
                m_credit[i] -= p_price[i];
                m_idle[i] = 0;
            end else begin
                m_open[i] = 0;
            end
        end else begin
            // Count idle cycles since the last unlock; relock when TIMEOUT have elapsed.
            m_idle[i]++;
            if (m_idle[i] >= p_timeout[i]) begin
                m_open[i] = 0;
                m_to[i] = 1;
            end
        end
    endtask

    task automatic cmp_inst(input int i, input string tag, input logic lk, input logic ulk,
                            input logic al, input logic to, input int cr, input int pc, input int cc);
        check({tag, ".locked"}, int'(lk), int'(!m_open[i]));
        check({tag, ".unlocked"}, int'(ulk), int'(m_open[i]));
        check({tag, ".alarm"}, int'(al), int'(m_alarm[i]));
        check({tag, ".timeout"}, int'(to), int'(m_to[i]));
        check({tag, ".credit"}, cr, m_credit[i]);
        check({tag, ".credit_le_max"}, int'(cr <= p_cmax[i]), 1);
        check({tag, ".pass_count"}, pc, m_pass[i]);
        check({tag, ".coin_count"}, cc, m_coins[i]);
    endtask

    always begin
        bit c, p, cl, r;
        @(posedge clk);
        c = coin; p = push; cl = clr; r = rst;
        model_step(0, c, p, cl, r);
        model_step(1, c, p, cl, r);
        #1;
        cmp_inst(0, "a", a_locked, a_unlocked, a_alarm, a_to, int'(a_credit), int'(a_pass), int'(a_coin));
        cmp_inst(1, "b", b_locked, b_unlocked, b_alarm, b_to, int'(b_credit), int'(b_pass), int'(b_coin));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic coin_pulse();
        coin = 1'b1; cyc(1);
        coin = 1'b0; cyc(1);
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        check("rst.locked", int'(a_locked), 1);
        check("rst.credit", int'(a_credit), 0);
        rst = 1'b0;
        cyc(2);

        // Two coins reach the fare.
        coin = 1'b1; cyc(1);
        check("t1.credit1", int'(a_credit), 1);
        check("t1.locked1", int'(a_locked), 1);
        coin = 1'b0; cyc(3);
        coin = 1'b1; cyc(1);
        check("t1.unlocked", int'(a_unlocked), 1);
        check("t1.credit0", int'(a_credit), 0);
        check("t1.coin_count", int'(a_coin), 2);
        coin = 1'b0;

        // One held push is one passage.
        push = 1'b1; cyc(1);
        check("t2.pass", int'(a_pass), 1);
        check("t2.locked", int'(a_locked), 1);
        cyc(4);
        check("t2.pass_held", int'(a_pass), 1);
        push = 1'b0; cyc(1);

        // Timeout relock with a coin mid-window.
        coin_pulse();
        coin = 1'b1; cyc(1);
        coin = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            coin = (t == 5);
            cyc(1);
            if (t < 10) check("t3.no_timeout", int'(a_to), 0);
        end
        coin = 1'b0;
        check("t3.timeout", int'(a_to), 1);
        check("t3.locked", int'(a_locked), 1);
        check("t3.credit", int'(a_credit), 1);
        cyc(1);
        check("t3.timeout_pulse", int'(a_to), 0);

        // Forced push alarm, credit while alarmed, clear, then unlock.
        rst = 1'b1; cyc(1);
        rst = 1'b0; cyc(1);
        push = 1'b1; cyc(1);
        check("t4.alarm", int'(a_alarm), 1);
        check("t4.b_no_alarm", int'(b_alarm), 0);
        check("t4.b_locked", int'(b_locked), 1);
        push = 1'b0;
        repeat (3) coin_pulse();
        check("t4.alarm_credit", int'(a_credit), 3);
        check("t4.alarm_locked", int'(a_locked), 1);
        clr = 1'b1; cyc(1);
        check("t4.cleared", int'(a_alarm), 0);
        check("t4.cleared_locked", int'(a_locked), 1);
        check("t4.cleared_credit", int'(a_credit), 3);
        clr = 1'b0; cyc(1);
        check("t4.unlocked", int'(a_unlocked), 1);
        check("t4.credit_after", int'(a_credit), 1);

        // Coin and push in the same cycle while locked: unlock, no pass, no alarm.
        push = 1'b1; cyc(1);
        push = 1'b0; cyc(1);
        check("t5.locked", int'(a_locked), 1);
        check("t5.credit1", int'(a_credit), 1);
        coin = 1'b1; push = 1'b1; cyc(1);
        check("t5.unlocked", int'(a_unlocked), 1);
        check("t5.no_alarm", int'(a_alarm), 0);
        check("t5.pass", int'(a_pass), 1);
        check("t5.credit0", int'(a_credit), 0);
        coin = 1'b0; push = 1'b0; cyc(1);

        // Nine coins, no pushes.
        rst = 1'b1; cyc(1);
        rst = 1'b0; cyc(1);
        repeat (9) coin_pulse();
        check("t5.coin9", int'(a_coin), 9);
        check("t5.coin9_b", int'(b_coin), 1);
        check("t5.credit_final", int'(a_credit), 5);

        // Five passages wrap the 2-bit counter.
        rst = 1'b1; cyc(1);
        rst = 1'b0; cyc(1);
        repeat (5) begin
            coin_pulse();
            coin_pulse();
            push = 1'b1; cyc(1);
            push = 1'b0; cyc(1);
        end
        check("t6.pass_wrap", int'(b_pass), 1);
        check("t6.pass_a", int'(a_pass), 5);

        // Reset mid-UNLOCKED with credit 3, coin held high across release.
        repeat (5) coin_pulse();
        check("t6.pre_credit", int'(a_credit), 3);
        check("t6.pre_unlocked", int'(a_unlocked), 1);
        rst = 1'b1; coin = 1'b1; cyc(1);
        check("t6.rst_locked", int'(a_locked), 1);
        check("t6.rst_unlocked", int'(a_unlocked), 0);
        check("t6.rst_credit", int'(a_credit), 0);
        check("t6.rst_pass", int'(a_pass), 0);
        check("t6.rst_coin", int'(a_coin), 0);
        rst = 1'b0; cyc(3);
        check("t6.held_coin", int'(a_coin), 0);
        coin = 1'b0; cyc(1);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            coin = ($urandom_range(0, 2) == 0);
            push = ($urandom_range(0, 5) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        rst = 1'b0; coin = 1'b0; push = 1'b0; clr = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
